// File: rtl/micro_sequencer.sv
// Micro-sequencer for the microcode control store: owns uPC, IR, halt/illegal flags and the retired counter.
// Optional feature: define MSEQ_ILLEGAL_TRAP_EN to trap undefined opcodes in uPC 4'hF instead of treating them as NOP.
module micro_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [18:0]      mem_data,
    input  logic             mem_ready,
    input  logic [1:0]       next,
    output logic [3:0]       upc,
    output logic [14:0]      r,
    output logic [3:0]       opcode,
    output logic             busy,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        U_FETCH0 = 4'h0, U_FETCH1 = 4'h1, U_DECODE = 4'h2,
        U_ADD0   = 4'h3, U_ADD1   = 4'h4, U_ADD2   = 4'h5,
        U_ADDI0  = 4'h6, U_ADDI1  = 4'h7, U_ADDI2  = 4'h8,
        U_RSV9   = 4'h9, U_RSVA   = 4'hA, U_RSVB   = 4'hB,
        U_RSVC   = 4'hC, U_RSVD   = 4'hD, U_HALT   = 4'hE,
        U_TRAP   = 4'hF
    } upc_e;

    localparam logic [1:0] NXT_INC  = 2'b00;
    localparam logic [1:0] NXT_DISP = 2'b01;
    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_HALT  = 4'hF;

    upc_e             upc_r, upc_nxt_s;
    logic [18:0]      ir_r, ir_nxt_s;
    logic             halted_r, halted_nxt_s;
    logic             illegal_r, illegal_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic [CNT_W-1:0] retired_r, retired_nxt_s;

    // Next-uPC, IR load, flag and counter decisions, highest priority first.
    always_comb begin
        upc_nxt_s     = upc_r;
        ir_nxt_s      = ir_r;
        halted_nxt_s  = halted_r;
        illegal_nxt_s = illegal_r;
        retired_nxt_s = retired_r;
        if (upc_r == U_HALT || upc_r == U_TRAP) begin
            upc_nxt_s = upc_r;
        end else if (upc_r >= U_RSV9) begin
            // unused micro-states recover to fetch without side effects
            upc_nxt_s = U_FETCH0;
        end else if (upc_r == U_FETCH0 && !run) begin
            upc_nxt_s = U_FETCH0;
        end else if (upc_r == U_FETCH1) begin
            if (mem_ready) begin
                ir_nxt_s  = mem_data;
                upc_nxt_s = U_DECODE;
            end else begin
                upc_nxt_s = U_FETCH1;
            end
        end else begin
            case (next)
                NXT_INC: upc_nxt_s = upc_e'(upc_r + 4'd1);
                NXT_DISP: begin
                    case (ir_r[18:15])
                        OP_ADD:  upc_nxt_s = U_ADD0;
                        OP_ADDI: upc_nxt_s = U_ADDI0;
                        OP_HALT: begin
                            upc_nxt_s    = U_HALT;
                            halted_nxt_s = 1'b1;
                        end
                        default: begin
`ifdef MSEQ_ILLEGAL_TRAP_EN
                            upc_nxt_s     = U_TRAP;
                            illegal_nxt_s = 1'b1;
`else
                            upc_nxt_s     = U_FETCH0;
                            illegal_nxt_s = 1'b0;
`endif
                        end
                    endcase
                end
                default: begin
                    upc_nxt_s = U_FETCH0;
                    if (upc_r == U_ADD2 || upc_r == U_ADDI2) begin
                        retired_nxt_s = retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        retired_nxt_s = retired_r;
                    end
                end
            endcase
        end
        if (upc_nxt_s == U_FETCH0 || upc_nxt_s == U_HALT || upc_nxt_s == U_TRAP) begin
            busy_nxt_s = 1'b0;
        end else begin
            busy_nxt_s = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            upc_r     <= U_FETCH0;
            ir_r      <= 19'h0_0000;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
            busy_r    <= 1'b0;
            retired_r <= {CNT_W{1'b0}};
        end else begin
            upc_r     <= upc_nxt_s;
            ir_r      <= ir_nxt_s;
            halted_r  <= halted_nxt_s;
            illegal_r <= illegal_nxt_s;
            busy_r    <= busy_nxt_s;
            retired_r <= retired_nxt_s;
        end
    end

    assign upc     = upc_r;
    assign r       = ir_r[14:0];
    assign opcode  = ir_r[18:15];
    assign busy    = busy_r;
    assign halted  = halted_r;
    assign illegal = illegal_r;
    assign retired = retired_r;

endmodule
